// File: rtl/simd_seq_ctrl.sv
// Instruction sequencer for the SIMD array: fetch/decode, per-PE control,
// load/store engine handshakes, single-level hardware loop and watchdog trap.
module simd_seq_ctrl #(
    parameter int NUM_PE = 4,
    parameter int ADDR_W = 4,
    parameter int TMO_W  = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [31:0]       INSTR,
    input  logic              INSTR_VALID,
    output logic              PC_INCR,
    output logic              PC_LOAD,
    output logic [7:0]        PC_TARGET,
    output logic [NUM_PE-1:0] MAC_EN,
    output logic [NUM_PE-1:0] RST_ACC,
    output logic [NUM_PE-1:0] WRITE_MAT,
    output logic [NUM_PE-1:0] MAT_SEL,
    output logic [NUM_PE-1:0] OUT_READY,
    input  logic              MAC_DONE,
    output logic [1:0]        DIMEN,
    output logic              ADDR_START,
    output logic              ADDR_RST,
    output logic [ADDR_W-1:0] ADDRESS,
    input  logic              FETCH_DONE,
    output logic              WRADDR_START,
    input  logic              STORE_DONE,
    input  logic              START_SIGNAL,
    output logic              STOP_SIGNAL,
    output logic              BUSY,
    output logic              ERR,
    output logic [2:0]        DBG_STATE,
    output logic [7:0]        DBG_LC,
    output logic              DBG_LA
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOADA = 3'd2,
        S_LOADB = 3'd3,
        S_MAC   = 3'd4,
        S_STORE = 3'd5,
        S_STOP  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    localparam logic [2:0] OP_LOADA = 3'd2;
    localparam logic [2:0] OP_LOADB = 3'd3;
    localparam logic [2:0] OP_MAC   = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;
    localparam logic [2:0] OP_STOP  = 3'd6;
    localparam logic [2:0] OP_LOOP  = 3'd7;

    // Last watchdog value that may still end normally; the edge after it traps.
    localparam logic [TMO_W-1:0] WDT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [7:0]        lc_q, lc_d;
    logic              la_q, la_d;
    logic [TMO_W-1:0]  wdt_q, wdt_d;

    logic              pc_incr_q, pc_incr_d;
    logic              pc_load_q, pc_load_d;
    logic [7:0]        pc_target_q, pc_target_d;
    logic [NUM_PE-1:0] mac_en_q, mac_en_d;
    logic [NUM_PE-1:0] rst_acc_q, rst_acc_d;
    logic [NUM_PE-1:0] write_mat_q, write_mat_d;
    logic [NUM_PE-1:0] mat_sel_q, mat_sel_d;
    logic [NUM_PE-1:0] out_ready_q, out_ready_d;
    logic [1:0]        dimen_q, dimen_d;
    logic              addr_start_q, addr_start_d;
    logic              addr_rst_q, addr_rst_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              wraddr_start_q, wraddr_start_d;
    logic              stop_q, stop_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              op_done;
    logic              counting;
    logic [NUM_PE-1:0] mask_d;
    logic              unused_bits;

    assign unused_bits = ^{INSTR[31:24], INSTR[6], ir_q};

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        lc_d        = lc_q;
        la_d        = la_q;
        pc_incr_d   = 1'b0;
        pc_load_d   = 1'b0;
        pc_target_d = '0;
        rst_acc_d   = '0;
        addr_rst_d  = 1'b0;
        op_done     = 1'b0;
        counting    = 1'b0;

        unique case (state_q)
            S_IDLE: if (START_SIGNAL) state_d = S_FETCH;
            S_FETCH: begin
                if (INSTR_VALID) begin
                    ir_d = INSTR;
                    unique case (INSTR[2:0])
                        OP_LOADA: state_d = S_LOADA;
                        OP_LOADB: state_d = S_LOADB;
                        OP_MAC:   state_d = S_MAC;
                        OP_STORE: state_d = S_STORE;
                        OP_STOP:  state_d = S_STOP;
                        OP_LOOP: begin
                            if (la_q && lc_q != 8'd0) begin
                                lc_d        = lc_q - 8'd1;
                                pc_load_d   = 1'b1;
                                pc_target_d = INSTR[23:16];
                            end else if (la_q) begin
                                la_d      = 1'b0;
                                pc_incr_d = 1'b1;
                            end else if (INSTR[15:8] != 8'd0) begin
                                lc_d        = INSTR[15:8] - 8'd1;
                                la_d        = 1'b1;
                                pc_load_d   = 1'b1;
                                pc_target_d = INSTR[23:16];
                            end else begin
                                pc_incr_d = 1'b1;
                            end
                        end
                        default: pc_incr_d = 1'b1;
                    endcase
                    if (INSTR[2:0] inside {OP_LOADA, OP_LOADB, OP_MAC, OP_STORE}) begin
                        pc_incr_d = 1'b1;
                        if (INSTR[5]) rst_acc_d = INSTR[7 +: NUM_PE];
                    end
                end
            end
            S_LOADA, S_LOADB: begin
                counting = 1'b1;
                op_done  = FETCH_DONE;
            end
            S_MAC: begin
                counting = 1'b1;
                op_done  = MAC_DONE;
            end
            S_STORE: begin
                counting = 1'b1;
                op_done  = STORE_DONE;
            end
            default: ;
        endcase

        // Done is checked before the watchdog so it wins a same-edge race.
        if (counting) begin
            if (op_done) begin
                state_d    = S_FETCH;
                addr_rst_d = (state_q != S_MAC);
            end else if (wdt_q == WDT_LAST) begin
                state_d = S_ERROR;
            end
        end
        wdt_d = (counting && state_d == state_q) ? wdt_q + 1'b1 : '0;

        // Registered outputs follow the state being entered at this edge.
        mask_d         = ir_d[7 +: NUM_PE];
        mac_en_d       = '0;
        write_mat_d    = '0;
        mat_sel_d      = '0;
        out_ready_d    = '0;
        dimen_d        = '0;
        addr_start_d   = 1'b0;
        address_d      = '0;
        wraddr_start_d = 1'b0;
        stop_d         = 1'b0;
        err_d          = 1'b0;
        busy_d         = (state_d inside {S_FETCH, S_LOADA, S_LOADB, S_MAC, S_STORE});

        unique case (state_d)
            S_LOADA, S_LOADB: begin
                write_mat_d  = mask_d;
                mat_sel_d    = (state_d == S_LOADA) ? mask_d : '0;
                addr_start_d = 1'b1;
                address_d    = ir_d[15 +: ADDR_W];
                dimen_d      = ir_d[4:3];
            end
            S_MAC: mac_en_d = mask_d;
            S_STORE: begin
                out_ready_d    = mask_d;
                wraddr_start_d = 1'b1;
                addr_start_d   = 1'b1;
                address_d      = ir_d[15 +: ADDR_W];
                dimen_d        = ir_d[4:3];
            end
            S_STOP: stop_d = 1'b1;
            S_ERROR: begin
                err_d      = 1'b1;
                addr_rst_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q        <= S_IDLE;
            ir_q           <= '0;
            lc_q           <= '0;
            la_q           <= 1'b0;
            wdt_q          <= '0;
            pc_incr_q      <= 1'b0;
            pc_load_q      <= 1'b0;
            pc_target_q    <= '0;
            mac_en_q       <= '0;
            rst_acc_q      <= '1;
            write_mat_q    <= '0;
            mat_sel_q      <= '0;
            out_ready_q    <= '0;
            dimen_q        <= '0;
            addr_start_q   <= 1'b0;
            addr_rst_q     <= 1'b1;
            address_q      <= '0;
            wraddr_start_q <= 1'b0;
            stop_q         <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            lc_q           <= lc_d;
            la_q           <= la_d;
            wdt_q          <= wdt_d;
            pc_incr_q      <= pc_incr_d;
            pc_load_q      <= pc_load_d;
            pc_target_q    <= pc_target_d;
            mac_en_q       <= mac_en_d;
            rst_acc_q      <= rst_acc_d;
            write_mat_q    <= write_mat_d;
            mat_sel_q      <= mat_sel_d;
            out_ready_q    <= out_ready_d;
            dimen_q        <= dimen_d;
            addr_start_q   <= addr_start_d;
            addr_rst_q     <= addr_rst_d;
            address_q      <= address_d;
            wraddr_start_q <= wraddr_start_d;
            stop_q         <= stop_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign PC_INCR      = pc_incr_q;
    assign PC_LOAD      = pc_load_q;
    assign PC_TARGET    = pc_target_q;
    assign MAC_EN       = mac_en_q;
    assign RST_ACC      = rst_acc_q;
    assign WRITE_MAT    = write_mat_q;
    assign MAT_SEL      = mat_sel_q;
    assign OUT_READY    = out_ready_q;
    assign DIMEN        = dimen_q;
    assign ADDR_START   = addr_start_q;
    assign ADDR_RST     = addr_rst_q;
    assign ADDRESS      = address_q;
    assign WRADDR_START = wraddr_start_q;
    assign STOP_SIGNAL  = stop_q;
    assign BUSY         = busy_q;
    assign ERR          = err_q;
    assign DBG_STATE    = state_q;
    assign DBG_LC       = lc_q;
    assign DBG_LA       = la_q;

endmodule
